// File: rtl/alu_sub_result_stage_pkg.sv
// Shared ALU definitions: default datapath width, status-flag bit positions,
// result-queue occupancy encoding and the buffered result entry layout.
package alu_sub_result_stage_pkg;

  localparam int ALU_WIDTH = 32;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int NUM_FLAGS = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic [NUM_FLAGS-1:0] flags;
  } alu_entry_t;

endpackage

// File: rtl/alu_sub_result_stage_sub.sv
// Combinational SUB unit of the ALU: wrapping difference a - b.
module alu_sub_result_stage_sub
  import alu_sub_result_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] diff_o
);

  assign diff_o = a_i - b_i;

endmodule

// File: rtl/alu_sub_result_stage.sv
// Registered result stage behind the SUB unit: 2-entry in-order queue of
// {difference, Z/N/C/V} with valid/ready on both sides and a registered in_ready.
module alu_sub_result_stage
  import alu_sub_result_stage_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic [CNT_W-1:0] op_count
);

  occ_e             state_q, state_d;
  alu_entry_t       head_q, head_d;
  alu_entry_t       tail_q, tail_d;
  alu_entry_t       new_entry;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic [WIDTH-1:0] diff;
  logic             push, pop;

  alu_sub_result_stage_sub #(.WIDTH(WIDTH)) u_sub (
    .a_i   (in1),
    .b_i   (in2),
    .diff_o(diff)
  );

  // Borrow is the unsigned compare; overflow means operands differ in sign
  // and the result sign disagrees with the minuend.
  function automatic logic [NUM_FLAGS-1:0] sub_flags(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b,
                                                      input logic [WIDTH-1:0] res);
    logic [NUM_FLAGS-1:0] f;
    f         = '0;
    f[FLAG_Z] = (res == '0);
    f[FLAG_N] = res[WIDTH-1];
    f[FLAG_C] = (a < b);
    f[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
    return f;
  endfunction

  assign new_entry = '{result: diff, flags: sub_flags(in1, in2, diff)};

  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = new_entry;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = new_entry;
        end else if (push) begin
          state_d = FULL;
          tail_d  = new_entry;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Ready is decided from next occupancy so it is a flop, never a comb path.
    in_ready_d = (state_d != FULL);
    op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_ready = in_ready_q;
  assign Out      = head_q.result;
  assign flag_z   = head_q.flags[FLAG_Z];
  assign flag_n   = head_q.flags[FLAG_N];
  assign flag_c   = head_q.flags[FLAG_C];
  assign flag_v   = head_q.flags[FLAG_V];
  assign op_count = op_count_q;

endmodule
